// File: rtl/dtlb_fill_ctl.sv
// dtlb_fill_ctl: DTLB miss queue and fill / invalidate sequencer.
// Buffers page misses in a small FIFO, issues one page walk at a time and
// writes the returned translation into the DTLB. Also performs single-page
// invalidates and a full 128-entry (8 ways x 16 sets) invalidate sweep.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   miss_*               miss request in (bit 0 of addr is pair-select)
//   walk_req_*           page-walk request out
//   walk_rsp_*           page-walk response in (no backpressure)
//   inv_*                invalidate request in (inv_all = full flush)
//   tlb_write_*          DTLB write port out
//   tlb_force_way*       DTLB way override out (sweep only)
//   fault_vld/addr       one-cycle walk-fault report
//   busy                 engine active or misses pending
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_fill_ctl #(
  parameter  int unsigned DW = `dtlbData_width,
  parameter  int unsigned QD = 4,
  localparam int unsigned AW = 51
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          miss_vld,
  input  logic [AW-1:0] miss_addr,
  output logic          miss_rdy,
  output logic          walk_req_vld,
  output logic [AW-1:0] walk_req_addr,
  input  logic          walk_req_rdy,
  input  logic          walk_rsp_vld,
  input  logic          walk_rsp_fault,
  input  logic [DW-1:0] walk_rsp_data0,
  input  logic [DW-1:0] walk_rsp_data1,
  input  logic [DW-1:0] walk_rsp_data2,
  input  logic          inv_vld,
  input  logic          inv_all,
  input  logic [AW-1:0] inv_addr,
  output logic          inv_rdy,
  output logic [AW-1:0] tlb_write_addr,
  output logic [DW-1:0] tlb_write_data0,
  output logic [DW-1:0] tlb_write_data1,
  output logic [DW-1:0] tlb_write_data2,
  output logic          tlb_write_wen,
  output logic          tlb_write_xstant,
  output logic          tlb_write_invl,
  output logic          tlb_force_way_en,
  output logic [2:0]    tlb_force_way,
  output logic          fault_vld,
  output logic [AW-1:0] fault_addr,
  output logic          busy
);

  localparam int unsigned QW = $clog2(QD);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned SW = 7;
  localparam logic [SW-1:0] SWEEP_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WREQ, S_WWAIT, S_FILL, S_INV1, S_SWEEP
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] q [QD];
  logic [QW-1:0] rd, wr, off;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] infl_addr, head;
  logic          infl_vld, infl_vld_nxt;
  logic [SW-1:0] sc, sc_nxt;
  logic          dup, push, pop, flt;

  logic          miss_rdy_nxt, inv_rdy_nxt, busy_nxt;
  logic          wreq_vld_nxt, fault_vld_nxt;
  logic [AW-1:0] wreq_addr_nxt, waddr_nxt, fault_addr_nxt;
  logic          wen_nxt, xstant_nxt, invl_nxt, fwe_nxt;
  logic [2:0]    fw_nxt;
  logic [DW-1:0] wd0_nxt, wd1_nxt, wd2_nxt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state, queue control and next output values
  always_comb begin
    state_nxt    = state;
    sc_nxt       = sc;
    infl_vld_nxt = infl_vld;
    pop          = 1'b0;
    flt          = 1'b0;
    dup          = 1'b0;
    off          = '0;

    // Drop a miss whose page is already queued or being walked
    for (int i = 0; i < QD; i++) begin
      off = QW'(i) - rd;
      if ((CW'(off) < cnt) && (q[i][AW-1:1] == miss_addr[AW-1:1])) dup = 1'b1;
    end
    if (infl_vld && (infl_addr[AW-1:1] == miss_addr[AW-1:1])) dup = 1'b1;
    push = miss_vld && miss_rdy && !dup;

    case (state)
      S_IDLE: begin
        if (inv_vld) begin
          state_nxt = inv_all ? S_SWEEP : S_INV1;
          sc_nxt    = '0;
        end else if ((cnt != '0) || push) begin
          state_nxt = S_WREQ;
        end
      end
      S_WREQ: begin
        if (walk_req_rdy) begin
          pop          = 1'b1;
          infl_vld_nxt = 1'b1;
          state_nxt    = S_WWAIT;
        end
      end
      S_WWAIT: begin
        if (walk_rsp_vld) begin
          if (walk_rsp_fault) begin
            flt          = 1'b1;
            infl_vld_nxt = 1'b0;
            state_nxt    = S_IDLE;
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        infl_vld_nxt = 1'b0;
        state_nxt    = S_IDLE;
      end
      S_INV1:  state_nxt = S_IDLE;
      S_SWEEP: begin
        if (sc == SWEEP_LAST) state_nxt = S_IDLE;
        else                  sc_nxt    = sc + SW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase

    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (pop && !push) cnt_nxt = cnt - CW'(1);

    // Head seen next cycle: an empty queue is being filled by this miss
    head = (cnt == '0) ? miss_addr : q[rd];

    miss_rdy_nxt   = (cnt_nxt != CW'(QD));
    inv_rdy_nxt    = (state_nxt == S_IDLE);
    busy_nxt       = (state_nxt != S_IDLE) || (cnt_nxt != '0);
    wreq_vld_nxt   = (state_nxt == S_WREQ);
    wreq_addr_nxt  = (state_nxt == S_WREQ) ? {head[AW-1:1], 1'b0} : '0;
    fault_vld_nxt  = flt;
    fault_addr_nxt = flt ? infl_addr : '0;

    wen_nxt    = 1'b0;
    xstant_nxt = 1'b0;
    invl_nxt   = 1'b0;
    fwe_nxt    = 1'b0;
    fw_nxt     = '0;
    waddr_nxt  = '0;
    wd0_nxt    = '0;
    wd1_nxt    = '0;
    wd2_nxt    = '0;
    case (state_nxt)
      S_FILL: begin
        wen_nxt   = 1'b1;
        waddr_nxt = infl_addr;
        wd0_nxt   = walk_rsp_data0;
        wd1_nxt   = walk_rsp_data1;
        wd2_nxt   = walk_rsp_data2;
      end
      S_INV1: begin
        wen_nxt    = 1'b1;
        xstant_nxt = 1'b1;
        invl_nxt   = 1'b1;
        waddr_nxt  = inv_addr;
      end
      S_SWEEP: begin
        wen_nxt    = 1'b1;
        xstant_nxt = 1'b1;
        invl_nxt   = 1'b1;
        fwe_nxt    = 1'b1;
        fw_nxt     = sc_nxt[6:4];
        waddr_nxt  = AW'(sc_nxt[3:0]);
      end
      default: ;
    endcase
  end

  // Miss queue storage; validity comes from rd/cnt
  always_ff @(posedge clk) begin
    if (push) q[wr] <= miss_addr;
  end

  // Pointers, in-flight walk, sweep counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd               <= '0;
      wr               <= '0;
      cnt              <= '0;
      infl_addr        <= '0;
      infl_vld         <= 1'b0;
      sc               <= '0;
      miss_rdy         <= 1'b1;
      inv_rdy          <= 1'b1;
      busy             <= 1'b0;
      walk_req_vld     <= 1'b0;
      walk_req_addr    <= '0;
      fault_vld        <= 1'b0;
      fault_addr       <= '0;
      tlb_write_wen    <= 1'b0;
      tlb_write_xstant <= 1'b0;
      tlb_write_invl   <= 1'b0;
      tlb_force_way_en <= 1'b0;
      tlb_force_way    <= '0;
      tlb_write_addr   <= '0;
      tlb_write_data0  <= '0;
      tlb_write_data1  <= '0;
      tlb_write_data2  <= '0;
    end else begin
      if (push) wr <= wr + QW'(1);
      if (pop) begin
        rd        <= rd + QW'(1);
        infl_addr <= q[rd];
      end
      cnt              <= cnt_nxt;
      infl_vld         <= infl_vld_nxt;
      sc               <= sc_nxt;
      miss_rdy         <= miss_rdy_nxt;
      inv_rdy          <= inv_rdy_nxt;
      busy             <= busy_nxt;
      walk_req_vld     <= wreq_vld_nxt;
      walk_req_addr    <= wreq_addr_nxt;
      fault_vld        <= fault_vld_nxt;
      fault_addr       <= fault_addr_nxt;
      tlb_write_wen    <= wen_nxt;
      tlb_write_xstant <= xstant_nxt;
      tlb_write_invl   <= invl_nxt;
      tlb_force_way_en <= fwe_nxt;
      tlb_force_way    <= fw_nxt;
      tlb_write_addr   <= waddr_nxt;
      tlb_write_data0  <= wd0_nxt;
      tlb_write_data1  <= wd1_nxt;
      tlb_write_data2  <= wd2_nxt;
    end
  end

endmodule

// File: tb/tb_dtlb_fill_ctl.sv
// Testbench for dtlb_fill_ctl: directed stimulus, a queue-based behavioural
// model compared against every output on every cycle, plus literal checks.
module tb_dtlb_fill_ctl;
  localparam int unsigned DW = 64;
  localparam int QD = 4;
  localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_FILL = 3, M_INV = 4, M_SWEEP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miss_vld, miss_rdy, walk_req_vld, walk_req_rdy;
  logic walk_rsp_vld, walk_rsp_fault, inv_vld, inv_all, inv_rdy;
  logic [50:0] miss_addr, walk_req_addr, inv_addr, tlb_write_addr, fault_addr;
  logic [DW-1:0] walk_rsp_data0, walk_rsp_data1, walk_rsp_data2;
  logic [DW-1:0] tlb_write_data0, tlb_write_data1, tlb_write_data2;
  logic tlb_write_wen, tlb_write_xstant, tlb_write_invl, tlb_force_way_en;
  logic [2:0] tlb_force_way;
  logic fault_vld, busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  dtlb_fill_ctl #(.DW(DW), .QD(QD)) dut (
    .clk(clk), .rst(rst),
    .miss_vld(miss_vld), .miss_addr(miss_addr), .miss_rdy(miss_rdy),
    .walk_req_vld(walk_req_vld), .walk_req_addr(walk_req_addr), .walk_req_rdy(walk_req_rdy),
    .walk_rsp_vld(walk_rsp_vld), .walk_rsp_fault(walk_rsp_fault),
    .walk_rsp_data0(walk_rsp_data0), .walk_rsp_data1(walk_rsp_data1), .walk_rsp_data2(walk_rsp_data2),
    .inv_vld(inv_vld), .inv_all(inv_all), .inv_addr(inv_addr), .inv_rdy(inv_rdy),
    .tlb_write_addr(tlb_write_addr),
    .tlb_write_data0(tlb_write_data0), .tlb_write_data1(tlb_write_data1), .tlb_write_data2(tlb_write_data2),
    .tlb_write_wen(tlb_write_wen), .tlb_write_xstant(tlb_write_xstant), .tlb_write_invl(tlb_write_invl),
    .tlb_force_way_en(tlb_force_way_en), .tlb_force_way(tlb_force_way),
    .fault_vld(fault_vld), .fault_addr(fault_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending misses as a queue, one walk at a time
  logic [50:0] mq[$];
  int          m_mode, m_sw;
  logic [50:0] m_infl, m_inv_addr, m_fa;
  bit          m_infl_v, m_fp;
  logic [63:0] m_d0, m_d1, m_d2;

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE; m_sw = 0; m_infl = '0; m_infl_v = 1'b0;
    m_inv_addr = '0; m_fa = '0; m_fp = 1'b0;
    m_d0 = '0; m_d1 = '0; m_d2 = '0;
  endtask

  task automatic model_step();
    bit dup, acc, take;
    dup = 1'b0; take = 1'b0;
    foreach (mq[i]) if (mq[i][50:1] == miss_addr[50:1]) dup = 1'b1;
    if (m_infl_v && m_infl[50:1] == miss_addr[50:1]) dup = 1'b1;
    acc = miss_vld && (mq.size() < QD) && !dup;
    m_fp = 1'b0;
    case (m_mode)
      M_IDLE:
        if (inv_vld) begin
          if (inv_all) begin m_mode = M_SWEEP; m_sw = 0; end
          else begin m_mode = M_INV; m_inv_addr = inv_addr; end
        end else if (mq.size() > 0 || acc) m_mode = M_REQ;
      M_REQ: if (walk_req_rdy) begin take = 1'b1; m_mode = M_WAIT; end
      M_WAIT:
        if (walk_rsp_vld) begin
          if (walk_rsp_fault) begin
            m_fp = 1'b1; m_fa = m_infl; m_infl_v = 1'b0; m_mode = M_IDLE;
          end else begin
            m_d0 = walk_rsp_data0; m_d1 = walk_rsp_data1; m_d2 = walk_rsp_data2;
            m_mode = M_FILL;
          end
        end
      M_FILL: begin m_infl_v = 1'b0; m_mode = M_IDLE; end
      M_INV: m_mode = M_IDLE;
      default: if (m_sw == 127) m_mode = M_IDLE; else m_sw++;
    endcase
    if (take) begin m_infl = mq.pop_front(); m_infl_v = 1'b1; end
    if (acc) mq.push_back(miss_addr);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    logic [50:0] e_wa, e_addr;
    logic        e_wr, e_inv, e_sw;
    if (chk_en) begin
      e_wr  = (m_mode == M_FILL) || (m_mode == M_INV) || (m_mode == M_SWEEP);
      e_inv = (m_mode == M_INV) || (m_mode == M_SWEEP);
      e_sw  = (m_mode == M_SWEEP);
      e_wa  = '0;
      if (m_mode == M_REQ && mq.size() > 0) e_wa = {mq[0][50:1], 1'b0};
      e_addr = '0;
      if (m_mode == M_FILL) e_addr = m_infl;
      else if (m_mode == M_INV) e_addr = m_inv_addr;
      else if (e_sw) e_addr = 51'(m_sw % 16);
      check("miss_rdy", 64'(miss_rdy), 64'(mq.size() < QD));
      check("inv_rdy", 64'(inv_rdy), 64'(m_mode == M_IDLE));
      check("busy", 64'(busy), 64'((m_mode != M_IDLE) || (mq.size() > 0)));
      check("walk_req_vld", 64'(walk_req_vld), 64'(m_mode == M_REQ));
      check("walk_req_addr", 64'(walk_req_addr), 64'(e_wa));
      check("wen", 64'(tlb_write_wen), 64'(e_wr));
      check("xstant", 64'(tlb_write_xstant), 64'(e_inv));
      check("invl", 64'(tlb_write_invl), 64'(e_inv));
      check("force_way_en", 64'(tlb_force_way_en), 64'(e_sw));
      check("force_way", 64'(tlb_force_way), e_sw ? 64'(m_sw / 16) : 64'd0);
      check("write_addr", 64'(tlb_write_addr), 64'(e_addr));
      check("data0", tlb_write_data0, (m_mode == M_FILL) ? m_d0 : 64'd0);
      check("data1", tlb_write_data1, (m_mode == M_FILL) ? m_d1 : 64'd0);
      check("data2", tlb_write_data2, (m_mode == M_FILL) ? m_d2 : 64'd0);
      check("fault_vld", 64'(fault_vld), 64'(m_fp));
      check("fault_addr", 64'(fault_addr), m_fp ? 64'(m_fa) : 64'd0);
    end
  end

  task automatic send_miss(input logic [50:0] a);
    @(negedge clk);
    miss_vld = 1'b1; miss_addr = a;
    @(negedge clk);
    miss_vld = 1'b0; miss_addr = '0;
  endtask

  // Accept the next walk request and answer it after lat extra cycles
  task automatic walk(input bit flt, input int lat, input logic [63:0] d0, d1, d2);
    walk_req_rdy = 1'b1;
    for (int i = 0; i < 30 && !walk_req_vld; i++) @(negedge clk);
    check("walk_req_seen", 64'(walk_req_vld), 64'd1);
    if (walk_req_vld) begin
      @(negedge clk);
      repeat (lat) @(negedge clk);
      walk_rsp_vld = 1'b1; walk_rsp_fault = flt;
      walk_rsp_data0 = d0; walk_rsp_data1 = d1; walk_rsp_data2 = d2;
      @(negedge clk);
      walk_rsp_vld = 1'b0; walk_rsp_fault = 1'b0;
      walk_rsp_data0 = '0; walk_rsp_data1 = '0; walk_rsp_data2 = '0;
    end
  endtask

  task automatic start_sweep();
    @(negedge clk);
    inv_vld = 1'b1; inv_all = 1'b1;
    @(negedge clk);
    inv_vld = 1'b0; inv_all = 1'b0;
  endtask

  task automatic count_wen(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!tlb_write_wen) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    bit found;
    miss_vld = 0; miss_addr = '0; walk_req_rdy = 0; walk_rsp_vld = 0; walk_rsp_fault = 0;
    walk_rsp_data0 = '0; walk_rsp_data1 = '0; walk_rsp_data2 = '0;
    inv_vld = 0; inv_all = 0; inv_addr = '0;
    #1 rst = 1'b0; chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_miss_rdy", 64'(miss_rdy), 64'd1);
    check("rst_inv_rdy", 64'(inv_rdy), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wen", 64'(tlb_write_wen), 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic fill, walk request one cycle after the miss
    walk_req_rdy = 1'b1;
    send_miss(51'h1234);
    check("lat_wreq_vld", 64'(walk_req_vld), 64'd1);
    check("lat_wreq_addr", 64'(walk_req_addr), 64'h1234);
    walk(1'b0, 0, 64'hA, 64'hB, 64'hC);
    check("fill_wen", 64'(tlb_write_wen), 64'd1);
    check("fill_xstant", 64'(tlb_write_xstant), 64'd0);
    check("fill_data0", tlb_write_data0, 64'hA);
    check("fill_data2", tlb_write_data2, 64'hC);
    check("fill_addr", 64'(tlb_write_addr), 64'h1234);
    @(negedge clk);
    check("fill_one_cycle", 64'(tlb_write_wen), 64'd0);

    // Odd pair-select: walk address drops bit 0, fill keeps it
    send_miss(51'h5679);
    check("odd_wreq_addr", 64'(walk_req_addr), 64'h5678);
    walk(1'b0, 2, 64'h11, 64'h22, 64'h33);
    check("odd_fill_addr", 64'(tlb_write_addr), 64'h5679);

    // Queue fill with walks stalled, duplicate dropped
    repeat (2) @(negedge clk);
    walk_req_rdy = 1'b0;
    send_miss(51'h100);
    send_miss(51'h202);
    send_miss(51'h304);
    send_miss(51'h203);
    check("dup_not_counted", 64'(miss_rdy), 64'd1);
    send_miss(51'h406);
    check("full_miss_rdy", 64'(miss_rdy), 64'd0);
    @(negedge clk); miss_vld = 1'b1; miss_addr = 51'h508;
    @(negedge clk);
    check("full_hold_rdy", 64'(miss_rdy), 64'd0);
    miss_vld = 1'b0; miss_addr = '0;
    walk(1'b0, 1, 64'h100, 64'h101, 64'h102);
    check("q0_addr", 64'(tlb_write_addr), 64'h100);
    walk(1'b0, 0, 64'h200, 64'h201, 64'h202);
    walk(1'b0, 3, 64'h300, 64'h301, 64'h302);
    walk(1'b0, 0, 64'h400, 64'h401, 64'h402);
    check("q3_addr", 64'(tlb_write_addr), 64'h406);
    repeat (3) @(negedge clk);
    check("q_drained", 64'(busy), 64'd0);

    // Stray response outside a walk is ignored
    @(negedge clk); walk_rsp_vld = 1'b1; walk_rsp_data0 = 64'hDEAD;
    @(negedge clk); walk_rsp_vld = 1'b0; walk_rsp_data0 = '0;
    check("stray_rsp_wen", 64'(tlb_write_wen), 64'd0);

    // Faulting walk
    send_miss(51'h40);
    walk(1'b1, 1, 64'h9, 64'h9, 64'h9);
    check("fault_vld", 64'(fault_vld), 64'd1);
    check("fault_addr", 64'(fault_addr), 64'h40);
    check("fault_no_wen", 64'(tlb_write_wen), 64'd0);
    @(negedge clk);
    check("fault_pulse_end", 64'(fault_vld), 64'd0);
    check("fault_no_wen2", 64'(tlb_write_wen), 64'd0);

    // Invalidate and miss together: invalidate wins
    @(negedge clk);
    inv_vld = 1'b1; inv_addr = 51'h777; miss_vld = 1'b1; miss_addr = 51'h900;
    @(negedge clk);
    inv_vld = 1'b0; inv_addr = '0; miss_vld = 1'b0; miss_addr = '0;
    check("inv1_wen", 64'(tlb_write_wen), 64'd1);
    check("inv1_invl", 64'(tlb_write_invl), 64'd1);
    check("inv1_addr", 64'(tlb_write_addr), 64'h777);
    check("inv1_no_wreq", 64'(walk_req_vld), 64'd0);
    @(negedge clk);
    check("inv1_idle_gap", 64'(walk_req_vld), 64'd0);
    @(negedge clk);
    check("inv1_then_wreq", 64'(walk_req_vld), 64'd1);
    check("inv1_then_addr", 64'(walk_req_addr), 64'h900);
    walk(1'b0, 0, 64'h90, 64'h91, 64'h92);

    // Full sweep with empty queue
    @(negedge clk);
    start_sweep();
    count_wen(n);
    check("sweep_len", 64'(n), 64'd128);
    check("sweep_busy_end", 64'(busy), 64'd0);

    // Sweep with a miss arriving mid-way; queue survives the sweep
    start_sweep();
    repeat (10) @(negedge clk);
    send_miss(51'hA01);
    count_wen(n);
    check("sweep2_rest", 64'(n), 64'd116);
    check("sweep2_busy", 64'(busy), 64'd1);
    walk(1'b0, 0, 64'hA0, 64'hA1, 64'hA2);
    check("sweep2_fill", 64'(tlb_write_addr), 64'hA01);

    // Reset at sweep count 50 (way 3, set 2)
    repeat (2) @(negedge clk);
    start_sweep();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tlb_force_way == 3'd3 && tlb_write_addr == 51'd2 && tlb_write_wen) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("sweep50_found", 64'(found), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("rst50_wen", 64'(tlb_write_wen), 64'd0);
    check("rst50_fwe", 64'(tlb_force_way_en), 64'd0);
    check("rst50_fw", 64'(tlb_force_way), 64'd0);
    check("rst50_addr", 64'(tlb_write_addr), 64'd0);
    check("rst50_miss_rdy", 64'(miss_rdy), 64'd1);
    check("rst50_inv_rdy", 64'(inv_rdy), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (30) begin @(negedge clk); if (tlb_write_wen) n++; end
    check("rst50_no_writes", 64'(n), 64'd0);

    // Reset during a walk: late response ignored
    send_miss(51'h881);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rstw_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); walk_rsp_vld = 1'b1; walk_rsp_data0 = 64'h55;
    @(negedge clk); walk_rsp_vld = 1'b0; walk_rsp_data0 = '0;
    check("rstw_no_wen", 64'(tlb_write_wen), 64'd0);
    check("rstw_idle", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtlb_fill_ctl.md
DTLB_FILL_CTL -- requirements
Module: dtlb_fill_ctl

Interface
REQ-001 Parameter DW, default `dtlbData_width, width of one translation data word.
REQ-002 Parameter QD, default 4, miss-queue depth; power of two, 2..8.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low; all state cleared while low.
REQ-005 miss_vld / miss_addr / miss_rdy  in / in / out  1 / 51 / 1  miss request; bit 0 is pair-select; page key = miss_addr[50:1].
REQ-006 walk_req_vld / walk_req_addr / walk_req_rdy  out / out / in  1 / 51 / 1  page-walk request.
REQ-007 walk_rsp_vld / walk_rsp_fault  in / in  1 / 1  walk response; no backpressure.
REQ-008 walk_rsp_data0 / walk_rsp_data1 / walk_rsp_data2  in  DW each  walk response data.
REQ-009 inv_vld / inv_all / inv_addr / inv_rdy  in / in / in / out  1 / 1 / 51 / 1  invalidate: single page, or full flush when inv_all=1.
REQ-010 tlb_write_addr  out  51  DTLB write address.
REQ-011 tlb_write_data0 / tlb_write_data1 / tlb_write_data2  out  DW each  DTLB write data.
REQ-012 tlb_write_wen / tlb_write_xstant / tlb_write_invl  out  1 each  DTLB write controls.
REQ-013 tlb_force_way_en / tlb_force_way  out / out  1 / 3  DTLB way override.
REQ-014 fault_vld / fault_addr  out / out  1 / 51  one-cycle walk-fault report.
REQ-015 busy  out  1  high when state != IDLE or queue non-empty.

Function
REQ-016 Miss queue SHALL be a QD-entry FIFO of 51-bit addresses; pointers wrap modulo QD; a separate count distinguishes full from empty.
REQ-017 miss_rdy SHALL be high when queue not full; a handshake (miss_vld & miss_rdy) SHALL enqueue only if miss_addr[50:1] matches no valid queue entry and not the in-flight walk page; a matching miss SHALL be accepted and dropped.
REQ-018 Enqueue while full SHALL NOT occur (miss_rdy low); enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-019 FSM states SHALL be IDLE, WREQ, WWAIT, FILL, INV1, SWEEP.
REQ-020 IDLE: inv_vld SHALL take priority over a non-empty queue; inv_rdy=1 only in IDLE; inv handshake -> INV1 (inv_all=0) or SWEEP (inv_all=1); else non-empty queue -> WREQ.
REQ-021 WREQ: walk_req_vld=1, walk_req_addr={queue head[50:1],1'b0}; on walk_req_rdy, pop head into the in-flight register and enter WWAIT.
REQ-022 WWAIT: on walk_rsp_vld with fault=0, capture data and enter FILL; with fault=1, pulse fault_vld for one cycle with fault_addr = in-flight address, and return to IDLE without any DTLB write.
REQ-023 FILL (one cycle): wen=1, xstant=0, invl=0, force_way_en=0, write_addr = in-flight address, data0..2 = captured response; then IDLE.
REQ-024 INV1 (one cycle): wen=1, xstant=1, invl=1, force_way_en=0, write_addr = inv_addr captured at handshake; then IDLE.
REQ-025 SWEEP: 7-bit counter {way[2:0],set[3:0]} from 0 to 127, one write per cycle: wen=1, xstant=1, invl=1, force_way_en=1, force_way=way, write_addr[3:0]=set, write_addr[50:4]=0; after 127 -> IDLE; total 128 cycles.
REQ-026 Outside FILL/INV1/SWEEP, all tlb_write_* outputs and force_way SHALL be 0.
REQ-027 Misses SHALL continue to be enqueued during any state; queue contents SHALL NOT be cleared by SWEEP.
REQ-028 walk_rsp_vld outside WWAIT SHALL be ignored.
REQ-029 Latency: miss accepted into an empty queue in IDLE, with walk_req_rdy=1 -> walk_req_vld on the next cycle; rsp at cycle N -> tlb_write_wen at N+1.

Reset
REQ-030 When rst=0: state IDLE, queue empty, pointers/count/sweep counter 0, in-flight invalid; all outputs 0 except miss_rdy=1 and inv_rdy=1.
REQ-031 Reset asserted mid-walk or mid-sweep SHALL abandon the operation; a walk response arriving after reset release SHALL be ignored.

Verification
REQ-032 Miss 0x1234 -> walk_req_addr=0x1234 (bit 0 cleared), rsp data {A,B,C} -> one FILL cycle: wen=1, xstant=0, invl=0, data0..2=A,B,C.
REQ-033 Five distinct misses with walk_req_rdy=0 (QD=4) -> first four accepted, miss_rdy=0 on the fifth; duplicate of entry 2 accepted with no count change.
REQ-034 Walk response with fault=1 for 0x40 -> fault_vld=1 for exactly one cycle, fault_addr=0x40, tlb_write_wen never asserted.
REQ-035 inv_vld and miss_vld asserted together in IDLE -> INV1 write (xstant=1, invl=1) first; walk request issued in the next available IDLE cycle.
REQ-036 inv_all=1 -> exactly 128 consecutive wen cycles, force_way 0..7 each across sets 0..15, then busy=0 if queue empty.
REQ-037 rst low at sweep count 50 -> all outputs at reset values immediately; after release, no further invalidate writes.
